// File: rtl/alu_seq_16bit_pkg.sv
// Shared definitions for the sequential 16-bit ALU: opcode encoding, FSM states, widths.
package alu_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLT = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_NOR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/shift_iter_16bit.sv
// Iterative shifter: loads a value and a count, then shifts one bit per cycle until the count runs out.
module shift_iter_16bit
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dir_right,
  input  logic [WIDTH-1:0]   load_data,
  input  logic [SHAMT_W-1:0] amount,
  output logic [WIDTH-1:0]   next_data,
  output logic               done
);

  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] cnt_q;

  // next_data is the value after the step being taken this cycle, so the final step can be captured directly.
  assign next_data = dir_right ? {1'b0, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};
  assign done      = (cnt_q == SHAMT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      cnt_q  <= amount;
    end else if (cnt_q != '0) begin
      data_q <= next_data;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_16bit.sv
// Sequential 16-bit ALU front-end: valid/ready request latch, iterative shifts, registered result and zero flag.
// Define ALU_OVERFLOW_FLAG_EN to add a registered signed-overflow flag for ADD/SUB.
module alu_seq_16bit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   result_q, result_d, exec_value, shift_next;
  logic               zero_q, rdy_q;
  logic               accept, shift_op, shift_load, shift_done, result_we;
  logic [SHAMT_W-1:0] shamt;

  // rdy_q keeps in_ready low until the first edge after reset is released.
  assign in_ready  = rdy_q && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign shamt     = b_q[SHAMT_W-1:0];
  assign shift_op  = is_shift(op_q);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  always_comb begin
    exec_value = a_q;
    case (op_q)
      OP_AND:  exec_value = a_q & b_q;
      OP_OR:   exec_value = a_q | b_q;
      OP_ADD:  exec_value = a_q + b_q;
      OP_SUB:  exec_value = a_q - b_q;
      OP_SLT:  exec_value = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_NOR:  exec_value = ~(a_q | b_q);
      default: exec_value = a_q;  // shift with zero amount passes A through
    endcase
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic ovf_value, ovf_q;

  always_comb begin
    ovf_value = 1'b0;
    if (op_q == OP_ADD)
      ovf_value = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (exec_value[WIDTH-1] != a_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      ovf_value = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (exec_value[WIDTH-1] != a_q[WIDTH-1]);
  end

  assign overflow = ovf_q;
`endif

  shift_iter_16bit u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (shift_load),
    .dir_right (op_q == OP_SRL),
    .load_data (a_q),
    .amount    (shamt),
    .next_data (shift_next),
    .done      (shift_done)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_load = 1'b0;
    result_we  = 1'b0;
    result_d   = exec_value;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        if (shift_op && (shamt != '0)) begin
          shift_load = 1'b1;
          state_d    = SHIFT;
        end else begin
          result_we = 1'b1;
          state_d   = DONE;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          result_we = 1'b1;
          result_d  = shift_next;
          state_d   = DONE;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (accept) begin
        op_q <= op_e'(op);
        a_q  <= input1;
        b_q  <= input2;
      end
      if (result_we) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
`ifdef ALU_OVERFLOW_FLAG_EN
        ovf_q    <= ovf_value;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_16bit.sv
// Self-checking bench for alu_seq_16bit: directed cases, backpressure, reset mid-shift, random requests vs. a reference model.
module tb_alu_seq_16bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] input1, input2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_16bit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .input1    (input1),
    .input2    (input2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the opcode table, using integer arithmetic.
  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    logic [3:0] sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[3:0];
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = (int'(a) + int'(b)) % 65536;
      3'd3: r = (int'(a) - int'(b) + 65536) % 65536;
      3'd4: r = (sa < sb) ? 1 : 0;
      3'd5: r = int'(a) * (2 ** sh);
      3'd6: r = int'(a) / (2 ** sh);
      default: r = 65535 - (a | b);
    endcase
    return r[15:0];
  endfunction

  function automatic logic ref_overflow(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    if (o == 3'd2) s = sa + sb;
    else if (o == 3'd3) s = sa - sb;
    else return 1'b0;
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic run_req(input string tag, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input int hold);
    int lat, exp_lat, guard;
    logic [15:0] exp_r;
    exp_r   = ref_result(o, a, b);
    exp_lat = (o == 3'd5 || o == 3'd6) ? 2 + int'(b[3:0]) : 2;
    guard   = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = o;
    input1   = a;
    input2   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    input1   = 16'($urandom);
    input2   = 16'($urandom);
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, 32'(result), 32'(exp_r));
    check({tag, " zero"}, 32'(zero), 32'(exp_r == 16'h0000));
    check({tag, " busy"}, 32'(in_ready), 32'd0);
`ifdef ALU_OVERFLOW_FLAG_EN
    check({tag, " overflow"}, 32'(overflow), 32'(ref_overflow(o, a, b)));
`endif
    repeat (hold) begin
      @(negedge clk);
      check({tag, " held"}, {15'd0, out_valid, result}, {15'd0, 1'b1, exp_r});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'd0;
    input1    = 16'h0000;
    input2    = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst zero", 32'(zero), 32'd1);
`ifdef ALU_OVERFLOW_FLAG_EN
    check("rst overflow", 32'(overflow), 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("post-rst ready low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("post-rst ready", 32'(in_ready), 32'd1);

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle out_ready", {30'd0, out_valid, in_ready}, 32'd1);

    run_req("or",      3'd1, 16'hF0F0, 16'h0FF0, 0);
    run_req("sub0",    3'd3, 16'h1234, 16'h1234, 0);
    run_req("addwrap", 3'd2, 16'hFFFF, 16'h0001, 0);
    run_req("addovf",  3'd2, 16'h7FFF, 16'h0001, 0);
    run_req("subovf",  3'd3, 16'h8000, 16'h0001, 0);
    run_req("sll15",   3'd5, 16'h0001, 16'h000F, 0);
    run_req("srl0",    3'd6, 16'hA5C3, 16'h0000, 0);
    run_req("srl7",    3'd6, 16'h8001, 16'hFFF7, 1);
    run_req("and",     3'd0, 16'hDEAD, 16'hBEEF, 0);
    run_req("nor",     3'd7, 16'h00FF, 16'h0F00, 0);
    run_req("sltpos",  3'd4, 16'h0001, 16'h8000, 0);

    // Backpressure: SLT result held while new requests are offered during DONE
    in_valid = 1'b1;
    op       = 3'd4;
    input1   = 16'hFFFF;
    input2   = 16'h0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("bp result", 32'(result), 32'h0001);
    check("bp zero", 32'(zero), 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~i[0];
      op       = 3'd2;
      input1   = 16'h0001;
      input2   = 16'h0002;
      @(negedge clk);
      check("bp hold result", 32'(result), 32'h0001);
      check("bp hold ready", {30'd0, in_ready, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp consumed", {30'd0, in_ready, out_valid}, 32'd2);
    run_req("bp next", 3'd2, 16'h0001, 16'h0002, 0);

    // Random requests against the reference model
    for (int i = 0; i < 24; i++)
      run_req("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));

    // Reset during SHIFT discards the pending result
    in_valid = 1'b1;
    op       = 3'd5;
    input1   = 16'h00FF;
    input2   = 16'h0008;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    check("midrst zero", 32'(zero), 32'd1);
    check("midrst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst ready low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("midrst ready", {29'd0, in_ready, out_valid, zero}, 32'd5);
    run_req("after rst", 3'd6, 16'hF000, 16'h0004, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
